axis_width_downsizer: RTL
=========================

# axis_width_downsizer

Single-clock AXI-Stream width converter that splits each wide input beat into RATIO narrow output beats, least-significant slice first. It sits where a proper width change is needed between a wide producer (e.g. 224-bit packed data) and a narrower consumer. Unlike a bare pass-through, it gives both sides a clean, protocol-correct TVALID/TREADY handshake. It holds one input beat and sustains full output throughput: one narrow beat per cycle, with no bubble between consecutive wide beats.

## Interface
- S_TDATA_WIDTH, default 224: input TDATA width.
- M_TDATA_WIDTH, default 32: output TDATA width; S_TDATA_WIDTH must be an exact multiple (RATIO = S_TDATA_WIDTH / M_TDATA_WIDTH ≥ 2).
- CLK  in  1: single clock; all logic on rising edge.
- RST  in  1: reset, synchronous, active-high.
- S_AXIS_TDATA  in  S_TDATA_WIDTH: wide input data.
- S_AXIS_TVALID  in  1: input valid.
- S_AXIS_TREADY  out  1: input ready.
- S_AXIS_TLAST  in  1: input packet end (only with AXIS_DOWNSIZER_TLAST_EN).
- M_AXIS_TDATA  out  M_TDATA_WIDTH: narrow output data.
- M_AXIS_TVALID  out  1: output valid.
- M_AXIS_TREADY  in  1: output ready.
- M_AXIS_TLAST  out  1: output packet end (only with AXIS_DOWNSIZER_TLAST_EN).

## Operation
- State: holding register `hold` (S_TDATA_WIDTH), `full` flag, slice index `idx` (0..RATIO-1), and `last_q` when TLAST is enabled.
- States: EMPTY (`full`=0) and HOLDING (`full`=1).
- Input accept: `s_fire` = S_AXIS_TVALID & S_AXIS_TREADY.
- Output accept: `m_fire` = M_AXIS_TVALID & M_AXIS_TREADY.
- Output signals:
  - M_AXIS_TVALID = `full`.
  - M_AXIS_TDATA = `hold[idx*M_TDATA_WIDTH +: M_TDATA_WIDTH]`.
- S_AXIS_TREADY = ~RST & (~`full` | (M_AXIS_TREADY & `idx`==RATIO-1)).
  - This is the only combinational input→output path, and it is intentional so that back-to-back wide beats see zero bubbles.
- EMPTY → HOLDING on `s_fire`: capture TDATA into `hold`, `idx`←0.
- HOLDING, `m_fire` with `idx`<RATIO-1: `idx`←`idx`+1.
- HOLDING, `m_fire` with `idx`==RATIO-1:
  - with simultaneous `s_fire`: reload `hold`, `idx`←0, stay HOLDING;
  - otherwise: `full`←0, `idx`←0, go to EMPTY.
- Backpressure: M_AXIS_TREADY low holds `idx`, `hold` and M_AXIS_TDATA stable. Once asserted, M_AXIS_TVALID never drops without `m_fire`.
- S_AXIS_TDATA is ignored whenever S_AXIS_TREADY is low.

## Timing
- Reset values, applied on the cycle RST is sampled high:
  - `full`=0, `idx`=0, `hold`=0;
  - M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0;
  - S_AXIS_TREADY=0 while RST is high, 1 on the first cycle after RST deasserts.
- Latency: a wide beat accepted at edge N presents slice 0 from cycle N+1.
- Throughput: with M_AXIS_TREADY held high, slices appear on RATIO consecutive cycles and the next wide beat's slice 0 follows immediately.
- Reset mid-beat: the held data is discarded, with no partial flush. Upstream must not assume delivery of any beat in flight.
- `idx` never exceeds RATIO-1, so no wrap-around arithmetic is needed beyond the explicit reset to 0.

## Configuration
- Macro AXIS_DOWNSIZER_TLAST_EN.
- Defined:
  - S_AXIS_TLAST and M_AXIS_TLAST ports exist;
  - `last_q` is captured with `hold`;
  - M_AXIS_TLAST = `last_q` & (`idx`==RATIO-1), so TLAST appears only on the final slice of a TLAST input beat.
- Undefined: the TLAST ports and `last_q` are absent, and no packet boundaries are conveyed.

## Structure
- Shared package `axis_downsizer_pkg`:
  - function computing RATIO and index width ($clog2(RATIO), min 1);
  - elaboration-time check that the widths divide exactly and RATIO ≥ 2.
- Single module; no sub-module. Slice select is an indexed part-select, not worth a separate block.

## Test plan
All scenarios use default widths (RATIO=7).
- Reset release:
  - stimulus: RST high for 3 cycles, then low;
  - response: S_AXIS_TREADY=0 during reset and 1 after; M_AXIS_TVALID=0 throughout.
- Single beat:
  - stimulus: input with slice k = 32'hA000_000k, k=0..6, M_AXIS_TREADY=1;
  - response: outputs A0000000..A0000006 on 7 consecutive cycles starting 1 cycle after accept, then TVALID=0.
- Back-to-back:
  - stimulus: 3 wide beats, S_AXIS_TVALID and M_AXIS_TREADY held high;
  - response: 21 contiguous output beats, in order, with no gaps; S_AXIS_TREADY high only on the last-slice cycles.
- Backpressure:
  - stimulus: M_AXIS_TREADY toggled 1,0,0,1 repeatedly;
  - response: data/idx stable while low, no slice dropped or duplicated, S_AXIS_TREADY stays low until slice 6 is accepted.
- Mid-beat reset:
  - stimulus: assert RST after slice 3 is accepted;
  - response: next cycle TVALID=0, idx=0; a following new beat emits its slice 0 first.
- TLAST (macro defined):
  - stimulus: beat with S_AXIS_TLAST=1 followed by beat with TLAST=0;
  - response: M_AXIS_TLAST=1 only on output beat 7 of 14.

Source files
------------

// File: rtl/axis_downsizer_pkg.sv
// Shared helpers for the AXI-Stream width downsizer: ratio/index sizing,
// configuration validity and the holding-register state encoding.
package axis_downsizer_pkg;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_HOLDING = 1'b1
    } ds_state_e;

    function automatic int ds_ratio(input int s_w, input int m_w);
        return s_w / m_w;
    endfunction

    function automatic int ds_idx_width(input int s_w, input int m_w);
        int r;
        r = ds_ratio(s_w, m_w);
        return ($clog2(r) < 1) ? 1 : $clog2(r);
    endfunction

    function automatic bit ds_cfg_ok(input int s_w, input int m_w);
        return (m_w > 0) && (s_w % m_w == 0) && (s_w / m_w >= 2);
    endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// Splits each wide AXI-Stream beat into RATIO narrow beats, LS slice first.
// Optional TLAST forwarding is enabled with AXIS_DOWNSIZER_TLAST_EN.
module axis_width_downsizer
    import axis_downsizer_pkg::*;
#(
    parameter int S_TDATA_WIDTH = 224,
    parameter int M_TDATA_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [S_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                     S_AXIS_TVALID,
    output logic                     S_AXIS_TREADY,
`ifdef AXIS_DOWNSIZER_TLAST_EN
    input  logic                     S_AXIS_TLAST,
    output logic                     M_AXIS_TLAST,
`endif
    output logic [M_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY
);

    localparam int RATIO = ds_ratio(S_TDATA_WIDTH, M_TDATA_WIDTH);
    localparam int IDX_W = ds_idx_width(S_TDATA_WIDTH, M_TDATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (!ds_cfg_ok(S_TDATA_WIDTH, M_TDATA_WIDTH)) begin : g_cfg_check
        $error("axis_width_downsizer: S_TDATA_WIDTH must be an exact multiple (>=2x) of M_TDATA_WIDTH");
    end

    ds_state_e                r_state;
    ds_state_e                w_state_nxt;
    logic [S_TDATA_WIDTH-1:0] r_hold;
    logic [S_TDATA_WIDTH-1:0] w_hold_nxt;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic                     w_full;
    logic                     w_last_slice;
    logic                     w_s_fire;
    logic                     w_m_fire;
`ifdef AXIS_DOWNSIZER_TLAST_EN
    logic                     r_last_q;
    logic                     w_last_nxt;
`endif

    // Handshake: a beat transfers on a cycle where VALID and READY are both
    // high; VALID never depends on READY, and once raised holds until it fires.
    assign w_full        = (r_state == ST_HOLDING);
    assign w_last_slice  = (r_idx == LAST_IDX);
    // Ready looks at the downstream ready so a new beat lands as the last slice leaves.
    assign S_AXIS_TREADY = ~RST & (~w_full | (M_AXIS_TREADY & w_last_slice));
    assign M_AXIS_TVALID = w_full;
    assign M_AXIS_TDATA  = r_hold[r_idx*M_TDATA_WIDTH +: M_TDATA_WIDTH];
    assign w_s_fire      = S_AXIS_TVALID & S_AXIS_TREADY;
    assign w_m_fire      = M_AXIS_TVALID & M_AXIS_TREADY;
`ifdef AXIS_DOWNSIZER_TLAST_EN
    assign M_AXIS_TLAST  = r_last_q & w_last_slice;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_idx_nxt   = r_idx;
`ifdef AXIS_DOWNSIZER_TLAST_EN
        w_last_nxt  = r_last_q;
`endif
        case (r_state)
            ST_EMPTY: begin
                if (w_s_fire) begin
                    w_state_nxt = ST_HOLDING;
                    w_hold_nxt  = S_AXIS_TDATA;
                    w_idx_nxt   = '0;
`ifdef AXIS_DOWNSIZER_TLAST_EN
                    w_last_nxt  = S_AXIS_TLAST;
`endif
                end
            end
            ST_HOLDING: begin
                if (w_m_fire) begin
                    if (!w_last_slice) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end else if (w_s_fire) begin
                        w_hold_nxt = S_AXIS_TDATA;
                        w_idx_nxt  = '0;
`ifdef AXIS_DOWNSIZER_TLAST_EN
                        w_last_nxt = S_AXIS_TLAST;
`endif
                    end else begin
                        w_state_nxt = ST_EMPTY;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_EMPTY;
            r_hold   <= '0;
            r_idx    <= '0;
`ifdef AXIS_DOWNSIZER_TLAST_EN
            r_last_q <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_hold   <= w_hold_nxt;
            r_idx    <= w_idx_nxt;
`ifdef AXIS_DOWNSIZER_TLAST_EN
            r_last_q <= w_last_nxt;
`endif
        end
    end

endmodule
